// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - write-back sources, scoreboard and register-file write port bundle
interface rf_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic                s0_valid;
  logic [AW-1:0]       s0_addr;
  logic [DW-1:0]       s0_data;
  logic                s0_ready;
  logic                s1_valid;
  logic [AW-1:0]       s1_addr;
  logic [DW-1:0]       s1_data;
  logic                s1_ready;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [(1<<AW)-1:0]  busy_o;
  logic                rf_we;
  logic [AW-1:0]       rf_wa;
  logic [DW-1:0]       rf_wd;

  modport master (
    output s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data, rsv_en, rsv_addr,
    input  s0_ready, s1_ready, busy_o, rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data, rsv_en, rsv_addr,
    output s0_ready, s1_ready, busy_o, rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin write-back arbiter with source-1 destination scoreboard
module rf_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int NR = 1 << AW;

  logic [NR-1:0] busy;
  logic [NR-1:0] busy_next;
  logic          last_grant;
  logic          s0_elig;
  logic          s1_elig;
  logic          grant0;
  logic          grant1;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          rf_we_q;
  logic [AW-1:0] rf_wa_q;
  logic [DW-1:0] rf_wd_q;

  // last_grant=1 means source 1 won most recently, so source 0 takes the next tie
  always_comb begin
    s0_elig  = bus.s0_valid && ((bus.s0_addr == '0) || !busy[bus.s0_addr]);
    s1_elig  = bus.s1_valid;
    grant0   = !rst && s0_elig && (!s1_elig || last_grant);
    grant1   = !rst && s1_elig && (!s0_elig || !last_grant);
    win_addr = grant1 ? bus.s1_addr : bus.s0_addr;
    win_data = grant1 ? bus.s1_data : bus.s0_data;
  end

  // Set is applied after clear so a same-cycle reservation keeps the register busy
  always_comb begin
    busy_next = busy;
    if (grant1) begin
      busy_next[bus.s1_addr] = 1'b0;
    end
    if (bus.rsv_en && (bus.rsv_addr != '0)) begin
      busy_next[bus.rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      last_grant <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
    end else begin
      busy <= busy_next;
      if (grant0 || grant1) begin
        last_grant <= grant1;
        rf_we_q    <= (win_addr != '0);
        rf_wa_q    <= win_addr;
        rf_wd_q    <= win_data;
      end else begin
        rf_we_q <= 1'b0;
      end
    end
  end

  assign bus.s0_ready = grant0;
  assign bus.s1_ready = grant1;
  assign bus.busy_o   = busy;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_wa    = rf_wa_q;
  assign bus.rf_wd    = rf_wd_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DW(32), .AW(5)) bus ();
  rf_wb_arbiter #(.DW(32), .AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  // reference model state
  bit          m_busy [32];
  int          m_last;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_last = 1;
    m_we = 0;
    m_wa = '0;
    m_wd = '0;
  endfunction

  function automatic void model_grant(output bit g0, output bit g1);
    bit e0, e1;
    e0 = bus.s0_valid && (bus.s0_addr == 0 || !m_busy[bus.s0_addr]);
    e1 = bus.s1_valid;
    if (e0 && e1) begin
      g0 = (m_last == 1);
      g1 = !g0;
    end else begin
      g0 = e0;
      g1 = e1;
    end
  endfunction

  function automatic void model_edge(bit g0, bit g1);
    if (g0 || g1) begin
      m_wa   = g1 ? bus.s1_addr : bus.s0_addr;
      m_wd   = g1 ? bus.s1_data : bus.s0_data;
      m_we   = (m_wa != 0);
      m_last = g1 ? 1 : 0;
    end else begin
      m_we = 0;
    end
    if (g1) m_busy[bus.s1_addr] = 0;
    if (bus.rsv_en && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1;
  endfunction

  task automatic advance(output bit g0, output bit g1);
    model_grant(g0, g1);
    @(posedge clk);
    #1;
    model_edge(g0, g1);
  endtask

  task automatic idle_inputs();
    bus.s0_valid = 0; bus.s0_addr = '0; bus.s0_data = '0;
    bus.s1_valid = 0; bus.s1_addr = '0; bus.s1_data = '0;
    bus.rsv_en = 0; bus.rsv_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    bit g0, g1;
    do_reset();
    bus.rsv_en = 1; bus.rsv_addr = 5'd4;
    bus.s0_valid = 1; bus.s0_addr = 5'd5; bus.s0_data = 32'h1234_5678;
    advance(g0, g1);
    idle_inputs();
    n_cmp++;
    if (bus.rf_we !== 1'b1 || bus.busy_o !== 32'h0000_0010) begin
      n_err++;
      $display("FAIL reset_setup: rf_we=%b busy=%h, required rf_we=1 busy=00000010", bus.rf_we, bus.busy_o);
    end
    bus.s0_valid = 1; bus.s1_valid = 1; bus.s0_addr = 5'd6;
    #2;
    rst = 1;
    #1;
    n_cmp++;
    if (bus.rf_we !== 1'b0 || bus.rf_wa !== 5'd0 || bus.rf_wd !== 32'd0 || bus.busy_o !== 32'd0) begin
      n_err++;
      $display("FAIL reset_async: we=%b wa=%0d wd=%h busy=%h, required all zero",
               bus.rf_we, bus.rf_wa, bus.rf_wd, bus.busy_o);
    end
    n_cmp++;
    if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: s0_ready=%b s1_ready=%b, required 0 0", bus.s0_ready, bus.s1_ready);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 0;
    model_reset();
  endtask

  task automatic test_single_source();
    bit g0, g1;
    do_reset();
    bus.s0_valid = 1; bus.s0_addr = 5'd5; bus.s0_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (bus.s0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_ready: s0_ready=%b, required 1", bus.s0_ready);
    end
    advance(g0, g1);
    bus.s0_valid = 0;
    n_cmp++;
    if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd5 || bus.rf_wd !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL single_write: we=%b wa=%0d wd=%h, required 1 5 deadbeef", bus.rf_we, bus.rf_wa, bus.rf_wd);
    end
    advance(g0, g1);
    n_cmp++;
    if (bus.rf_we !== 1'b0) begin
      n_err++;
      $display("FAIL single_after: rf_we=%b, required 0", bus.rf_we);
    end
  endtask

  task automatic test_round_robin();
    bit g0, g1;
    int exp_wa [4] = '{3, 4, 3, 4};
    do_reset();
    bus.s0_valid = 1; bus.s0_addr = 5'd3; bus.s0_data = 32'h3333_0000;
    bus.s1_valid = 1; bus.s1_addr = 5'd4; bus.s1_data = 32'h4444_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (bus.s0_ready !== (i % 2 == 0) || bus.s1_ready !== (i % 2 == 1)) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: s0_ready=%b s1_ready=%b, required %b %b",
                 i, bus.s0_ready, bus.s1_ready, (i % 2 == 0), (i % 2 == 1));
      end
      advance(g0, g1);
      n_cmp++;
      if (bus.rf_wa !== exp_wa[i][4:0] || bus.rf_we !== 1'b1) begin
        n_err++;
        $display("FAIL rr_wa[%0d]: rf_wa=%0d we=%b, required %0d 1", i, bus.rf_wa, bus.rf_we, exp_wa[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard_block();
    bit g0, g1;
    do_reset();
    bus.rsv_en = 1; bus.rsv_addr = 5'd7;
    advance(g0, g1);
    bus.rsv_en = 0;
    n_cmp++;
    if (bus.busy_o[7] !== 1'b1) begin
      n_err++;
      $display("FAIL sb_reserve: busy[7]=%b, required 1", bus.busy_o[7]);
    end
    bus.s0_valid = 1; bus.s0_addr = 5'd7; bus.s0_data = 32'hA5A5_0007;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (bus.s0_ready !== 1'b0) begin
        n_err++;
        $display("FAIL sb_blocked[%0d]: s0_ready=%b, required 0", i, bus.s0_ready);
      end
      advance(g0, g1);
    end
    bus.s1_valid = 1; bus.s1_addr = 5'd7; bus.s1_data = 32'h11;
    #1;
    n_cmp++;
    if (bus.s1_ready !== 1'b1 || bus.s0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL sb_s1_grant: s1_ready=%b s0_ready=%b, required 1 0", bus.s1_ready, bus.s0_ready);
    end
    advance(g0, g1);
    bus.s1_valid = 0;
    n_cmp++;
    if (bus.busy_o[7] !== 1'b0 || bus.rf_wd !== 32'h11) begin
      n_err++;
      $display("FAIL sb_s1_write: busy[7]=%b rf_wd=%h, required 0 00000011", bus.busy_o[7], bus.rf_wd);
    end
    #1;
    n_cmp++;
    if (bus.s0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL sb_unblock: s0_ready=%b, required 1", bus.s0_ready);
    end
    advance(g0, g1);
    bus.s0_valid = 0;
    n_cmp++;
    if (bus.rf_wd !== 32'hA5A5_0007 || bus.rf_wa !== 5'd7 || bus.rf_we !== 1'b1) begin
      n_err++;
      $display("FAIL sb_s0_write: wd=%h wa=%0d we=%b, required a5a50007 7 1", bus.rf_wd, bus.rf_wa, bus.rf_we);
    end
  endtask

  task automatic test_set_clear_collide();
    bit g0, g1;
    do_reset();
    bus.rsv_en = 1; bus.rsv_addr = 5'd9;
    advance(g0, g1);
    bus.s1_valid = 1; bus.s1_addr = 5'd9; bus.s1_data = 32'h99;
    #1;
    n_cmp++;
    if (bus.s1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL collide_grant: s1_ready=%b, required 1", bus.s1_ready);
    end
    advance(g0, g1);
    idle_inputs();
    n_cmp++;
    if (bus.busy_o[9] !== 1'b1) begin
      n_err++;
      $display("FAIL collide_busy: busy[9]=%b, required 1", bus.busy_o[9]);
    end
  endtask

  task automatic test_register_zero();
    bit g0, g1;
    do_reset();
    bus.s1_valid = 1; bus.s1_addr = 5'd0; bus.s1_data = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (bus.s1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL r0_ready: s1_ready=%b, required 1", bus.s1_ready);
    end
    advance(g0, g1);
    bus.s1_valid = 0;
    n_cmp++;
    if (bus.rf_we !== 1'b0) begin
      n_err++;
      $display("FAIL r0_we: rf_we=%b, required 0", bus.rf_we);
    end
    bus.rsv_en = 1; bus.rsv_addr = 5'd0;
    advance(g0, g1);
    bus.rsv_en = 0;
    n_cmp++;
    if (bus.busy_o !== 32'd0) begin
      n_err++;
      $display("FAIL r0_reserve: busy=%h, required 00000000", bus.busy_o);
    end
  endtask

  task automatic test_random();
    bit g0 = 0, g1 = 0, e0, e1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!bus.s0_valid || g0) begin
        bus.s0_valid = ($urandom % 4) != 0;
        bus.s0_addr  = 5'($urandom % 8);
        bus.s0_data  = $urandom;
      end
      if (!bus.s1_valid || g1) begin
        bus.s1_valid = ($urandom % 3) == 0;
        bus.s1_addr  = 5'($urandom % 8);
        bus.s1_data  = $urandom;
      end
      bus.rsv_en   = ($urandom % 4) == 0;
      bus.rsv_addr = 5'($urandom % 8);
      #1;
      model_grant(e0, e1);
      n_cmp++;
      if (bus.s0_ready !== e0 || bus.s1_ready !== e1) begin
        n_err++;
        $display("FAIL rand_ready[%0d]: s0_ready=%b s1_ready=%b, required %b %b",
                 i, bus.s0_ready, bus.s1_ready, e0, e1);
      end
      advance(g0, g1);
      n_cmp++;
      if (bus.rf_we !== m_we || bus.rf_wa !== m_wa || bus.rf_wd !== m_wd || bus.busy_o !== model_busy_vec()) begin
        n_err++;
        $display("FAIL rand_out[%0d]: we=%b wa=%0d wd=%h busy=%h, required %b %0d %h %h",
                 i, bus.rf_we, bus.rf_wa, bus.rf_wd, bus.busy_o, m_we, m_wa, m_wd, model_busy_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #2;
    test_reset();
    test_single_source();
    test_round_robin();
    test_scoreboard_block();
    test_set_clear_collide();
    test_register_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and destination scoreboard for the 32x32 register file. Two writers share the register file's single write port: source 0 is the ALU/load datapath, and source 1 is a long-latency unit such as a multiplier/divider. The block grants one write per cycle with round-robin fairness and registers the winner onto the register file's write port. It also keeps a busy bit per register reserved by source 1, and blocks source-0 writes to those registers until source 1 has written them.

## Interface
- DW, 32, data width
- AW, 5, register address width (2^AW registers)
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- s0_valid  in  1  source 0 has a write pending
- s0_addr  in  AW  source 0 destination register
- s0_data  in  DW  source 0 write data
- s0_ready  out  1  source 0 write accepted this cycle
- s1_valid  in  1  source 1 has a write pending
- s1_addr  in  AW  source 1 destination register
- s1_data  in  DW  source 1 write data
- s1_ready  out  1  source 1 write accepted this cycle
- rsv_en  in  1  reserve a destination for a source-1 operation being issued
- rsv_addr  in  AW  register to reserve
- busy_o  out  2^AW  per-register pending-write flags
- rf_we  out  1  register file write enable
- rf_wa  out  AW  register file write address
- rf_wd  out  DW  register file write data

## Operation
- **Handshake.** A transfer completes on a posedge when valid=1 and ready=1. A source must hold addr and data stable while valid=1 and ready=0.
- **Eligibility.**
  - s0 is eligible when s0_valid=1 and busy_o[s0_addr]=0. Writes to register 0 are exempt from this check.
  - s1 is eligible when s1_valid=1.
- **Arbitration.**
  - One eligible source: that source is granted.
  - Both eligible: grant the source not granted most recently, tracked in a 1-bit last_grant register.
  - last_grant updates only on a completed grant.
  - After reset last_grant=1, so s0 wins the first tie.
- **Ready outputs.** s0_ready and s1_ready are the combinational grant. At most one is high in a cycle.
- **Output stage.** On a grant, the granted addr and data are captured into rf_wa/rf_wd, and rf_we is set to 1 only if the addr is nonzero.
  - A granted write to register 0 completes its handshake but produces rf_we=0.
  - With no grant, rf_we=0 and rf_wa/rf_wd hold their previous values.
- **Scoreboard.**
  - rsv_en=1 with rsv_addr≠0 sets busy[rsv_addr] at the posedge. Reserving register 0 is ignored, so busy_o[0] is always 0.
  - A completed s1 grant clears busy[s1_addr].
  - A set and a clear of the same register in the same cycle: set wins.
  - Reserving an already-busy register leaves it busy. There is no error flag and no count.
  - An s1 write to a register that is not busy is granted normally, and the clear has no effect.
- **Reset.** Reset (mid-operation included) discards all reservations and any in-flight output.

## Timing
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, busy_o=0, last_grant=1. s0_ready and s1_ready are 0 while rst=1.
- Write latency: a grant at posedge N drives rf_we/rf_wa/rf_wd during cycle N..N+1. The register file commits at the negedge within that cycle.
- busy_o is registered. A reservation at posedge N is visible from N. A source-0 request to that register in cycle N+1 is blocked.
- A clear at posedge N unblocks a source-0 request in the next cycle. Source 0 therefore never writes before or on the same edge as the source-1 write it must follow.
- Worst-case wait under continuous contention: 1 cycle for s1. For s0, 1 cycle plus the time its destination stays busy.
- There is no combinational path from rf_* to any input. The ready outputs depend on valid, addr, busy and last_grant only.

## Test plan
- **Reset.** Assert rst asynchronously mid-cycle while rf_we=1 and busy_o=0x0000_0010 -> rf_we=0, rf_wa=0, rf_wd=0 and busy_o=0 immediately, and s0_ready=s1_ready=0.
- **Single source.** s0_valid with addr=5, data=0xDEADBEEF -> s0_ready=1 the same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; the following cycle rf_we=0.
- **Round-robin.** Hold s0 (addr 3) and s1 (addr 4) valid for 4 cycles, no reservations -> grants alternate s0, s1, s0, s1, and rf_wa sequence is 3, 4, 3, 4.
- **Scoreboard block.**
  - Reserve rsv_addr=7. s0 writes addr 7 for 3 cycles -> s0_ready=0 throughout.
  - s1 writes addr 7 with data 0x11 -> s1 granted, busy_o[7] clears.
  - s0 granted on the next cycle.
  - rf_wd order is 0x11 then the s0 data.
- **Set and clear collide.** In one cycle, s1 is granted addr 9 while rsv_en=1 with rsv_addr=9 -> busy_o[9] stays 1 after the edge.
- **Register 0.** s1 writes addr 0, data 0xFFFFFFFF -> s1_ready=1; next cycle rf_we=0. rsv_en with rsv_addr=0 -> busy_o stays 0.
